ahbl_dw64to32_bridge: RTL and testbench



---
 rtl/ahbl_pkg.sv | 6 +
 rtl/ahbl_dw64to32_bridge.sv | 106 ++++++++++
 tb/tb_ahbl_dw64to32_bridge.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/ahbl_pkg.sv
// ahbl_pkg: shared AHB-Lite transfer/size encodings and the downsizer data-phase states.
package ahbl_pkg;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] BYTE = 3'd0, HALF = 3'd1, WORD = 3'd2, DWORD = 3'd3;
  typedef enum logic [2:0] {D_NONE, D_SGL, D_LO, D_HI, D_E1, D_E2} dstate_e;
endpackage

// File: rtl/ahbl_dw64to32_bridge.sv
// ahbl_dw64to32_bridge: 64-to-32-bit AHB-Lite downsizer; DWORD transfers become two WORD beats.
// Define AHBL_DW_BRIDGE_ERR_EN to answer oversized/misaligned DWORD transfers with a local ERROR.
module ahbl_dw64to32_bridge
  import ahbl_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] S_HADDR,
  input  logic [1:0]    S_HTRANS,
  input  logic          S_HWRITE,
  input  logic [2:0]    S_HSIZE,
  input  logic [63:0]   S_HWDATA,
  output logic [63:0]   S_HRDATA,
  output logic          S_HREADYOUT,
  output logic          S_HRESP,
  output logic [AW-1:0] M_HADDR,
  output logic [1:0]    M_HTRANS,
  output logic          M_HWRITE,
  output logic [2:0]    M_HSIZE,
  output logic [31:0]   M_HWDATA,
  input  logic [31:0]   M_HRDATA,
  input  logic          M_HREADY,
  input  logic          M_HRESP
);
  dstate_e state, state_nx;
  logic [AW-1:0] addr_q, a_addr;
  logic [2:0] size_q;
  logic write_q, accept, dword, err, lo_ok, unused_ok;
  logic [31:0] lo_rdata;
  assign dword = S_HSIZE >= DWORD;
  assign a_addr = dword ? {S_HADDR[AW-1:3], 3'b000} : S_HADDR;
`ifdef AHBL_DW_BRIDGE_ERR_EN
  assign err = (S_HSIZE > DWORD) || (S_HSIZE == DWORD && S_HADDR[2:0] != 3'b000);
`else
  assign err = 1'b0;
`endif
  assign accept = S_HREADYOUT & S_HTRANS[1];
  assign lo_ok = state == D_LO && M_HREADY && !M_HRESP;
  assign unused_ok = ^size_q;
  always_comb begin
    M_HADDR = a_addr;
    M_HTRANS = err ? IDLE : S_HTRANS;
    M_HWRITE = S_HWRITE;
    M_HSIZE = dword ? WORD : S_HSIZE;
    M_HWDATA = (state == D_HI || (state == D_SGL && addr_q[2])) ? S_HWDATA[63:32] : S_HWDATA[31:0];
    S_HRDATA = 64'd0;
    S_HREADYOUT = 1'b1;
    S_HRESP = 1'b0;
    case (state)
      D_SGL: begin
        S_HRDATA = {M_HRDATA, M_HRDATA};
        S_HREADYOUT = M_HREADY;
        S_HRESP = M_HRESP;
      end
      D_LO: begin
        S_HREADYOUT = M_HRESP & M_HREADY;
        S_HRESP = M_HRESP;
        // beat 2 is issued by the bridge; an ERROR on beat 1 cancels it, then pass-through resumes
        if (!M_HRESP) begin
          M_HADDR = {addr_q[AW-1:3], 1'b1, addr_q[1:0]};
          M_HTRANS = SEQ;
          M_HSIZE = WORD;
          M_HWRITE = write_q;
        end else if (!M_HREADY) M_HTRANS = IDLE;
      end
      D_HI: begin
        S_HRDATA = {M_HRDATA, lo_rdata};
        S_HREADYOUT = M_HREADY;
        S_HRESP = M_HRESP;
      end
`ifdef AHBL_DW_BRIDGE_ERR_EN
      D_E1: begin
        S_HREADYOUT = 1'b0;
        S_HRESP = 1'b1;
        M_HTRANS = IDLE;
      end
      D_E2: begin
        S_HREADYOUT = M_HREADY;
        S_HRESP = 1'b1;
      end
`endif
      default: ;
    endcase
    state_nx = S_HREADYOUT ? (!S_HTRANS[1] ? D_NONE : err ? D_E1 : dword ? D_LO : D_SGL)
             : lo_ok ? D_HI : state == D_E1 ? D_E2 : state;
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= D_NONE;
      addr_q <= '0;
      size_q <= '0;
      write_q <= 1'b0;
      lo_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_q <= a_addr;
        size_q <= S_HSIZE;
        write_q <= S_HWRITE;
      end
      if (lo_ok) lo_rdata <= M_HRDATA;
    end
  end
endmodule

// File: tb/tb_ahbl_dw64to32_bridge.sv
// tb_ahbl_dw64to32_bridge: scoreboard bench with an upstream master task and a downstream slave model.
module tb_ahbl_dw64to32_bridge;
  import ahbl_pkg::*;
  logic HCLK, HRESETn;
  logic [31:0] S_HADDR, M_HADDR, M_HWDATA, M_HRDATA;
  logic [1:0] S_HTRANS, M_HTRANS;
  logic S_HWRITE, S_HREADYOUT, S_HRESP, M_HWRITE, M_HREADY, M_HRESP;
  logic [2:0] S_HSIZE, M_HSIZE;
  logic [63:0] S_HWDATA, S_HRDATA;

  ahbl_dw64to32_bridge #(.AW(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE),
    .S_HWDATA(S_HWDATA), .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HWDATA(M_HWDATA), .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct packed {logic [31:0] addr; logic [1:0] trans; logic [2:0] size; logic write; logic [31:0] wdata;} dn_t;
  typedef struct packed {logic [63:0] rdata; logic resp; logic rd; logic [7:0] stall;} up_t;
  dn_t dn_q[$];
  up_t up_q[$];
  logic [31:0] wq[$];
  logic [31:0] mem[logic [31:0]];
  int waits[logic [31:0]];
  bit errs[logic [31:0]];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdm(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : ~a;
  endfunction
  function automatic int wt(input logic [31:0] a);
    return (!errs.exists(a) && waits.exists(a)) ? waits[a] : 0;
  endfunction

  // downstream slave: per-address wait states, two-cycle ERROR on listed addresses
  logic s_act, s_wr, s_err, s_errc;
  int s_wait;
  logic [31:0] s_rdata;
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_errc <= 1'b0; s_wait <= 0; s_rdata <= '0;
    end else if (M_HREADY) begin
      s_act <= M_HTRANS[1];
      s_wr <= M_HWRITE;
      s_err <= errs.exists(M_HADDR);
      s_errc <= 1'b0;
      s_wait <= wt(M_HADDR);
      s_rdata <= rdm(M_HADDR);
    end else if (s_err) s_errc <= 1'b1;
    else s_wait <= s_wait - 1;
  end
  assign M_HREADY = !s_act || (s_err ? s_errc : s_wait == 0);
  assign M_HRESP = s_act && s_err;
  assign M_HRDATA = s_rdata;

  // reference model: what the bridge should issue downstream and return upstream
  task automatic expect_xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr, input logic [63:0] wd);
    logic [31:0] a0, a1;
    logic r;
`ifdef AHBL_DW_BRIDGE_ERR_EN
    if (sz > DWORD || (sz == DWORD && a[2:0] != 3'b000)) begin
      up_q.push_back('{rdata: 64'd0, resp: 1'b1, rd: !wr, stall: 8'd1});
      return;
    end
`endif
    if (sz < DWORD) begin
      dn_q.push_back('{addr: a, trans: NONSEQ, size: sz, write: wr, wdata: a[2] ? wd[63:32] : wd[31:0]});
      r = errs.exists(a);
      up_q.push_back('{rdata: {rdm(a), rdm(a)}, resp: r, rd: !wr, stall: 8'(r ? 1 : wt(a))});
    end else begin
      a0 = {a[31:3], 3'b000};
      a1 = a0 | 32'd4;
      dn_q.push_back('{addr: a0, trans: NONSEQ, size: WORD, write: wr, wdata: wd[31:0]});
      if (errs.exists(a0)) up_q.push_back('{rdata: 64'd0, resp: 1'b1, rd: !wr, stall: 8'd1});
      else begin
        dn_q.push_back('{addr: a1, trans: SEQ, size: WORD, write: wr, wdata: wd[63:32]});
        r = errs.exists(a1);
        up_q.push_back('{rdata: {rdm(a1), rdm(a0)}, resp: r, rd: !wr, stall: 8'(1 + wt(a0) + (r ? 1 : wt(a1)))});
      end
    end
  endtask

  // monitor: sampled on the falling edge, inputs change just after the rising edge
  logic u_act;
  int stall;
  always @(negedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      u_act <= 1'b0;
      stall <= 0;
    end else begin
      if (s_act && s_wr && M_HREADY) begin
        if (wq.size() > 0) begin
          chk("dn_wdata", M_HWDATA, wq[0]);
          void'(wq.pop_front());
        end else chk("dn_wdata_extra", wq.size(), 1);
      end
      if (M_HTRANS[1] && M_HREADY) begin
        if (dn_q.size() > 0) begin
          chk("dn_addr", {M_HADDR, M_HTRANS, M_HSIZE, M_HWRITE},
              {dn_q[0].addr, dn_q[0].trans, dn_q[0].size, dn_q[0].write});
          if (dn_q[0].write) wq.push_back(dn_q[0].wdata);
          void'(dn_q.pop_front());
        end else chk("dn_extra", dn_q.size(), 1);
      end
      if (u_act && S_HREADYOUT) begin
        if (up_q.size() > 0) begin
          chk("up_resp", S_HRESP, up_q[0].resp);
          chk("up_stall", stall, up_q[0].stall);
          if (up_q[0].rd && !up_q[0].resp) chk("up_rdata", S_HRDATA, up_q[0].rdata);
          void'(up_q.pop_front());
        end else chk("up_extra", up_q.size(), 1);
      end
      u_act <= S_HREADYOUT ? S_HTRANS[1] : u_act;
      stall <= S_HREADYOUT ? 0 : stall + 1;
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [2:0] sz, input logic wr, input logic [63:0] wd);
    logic ok;
    ok = 1'b0;
    S_HADDR = a; S_HTRANS = NONSEQ; S_HSIZE = sz; S_HWRITE = wr;
    expect_xfer(a, sz, wr, wd);
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge HCLK);
      ok = S_HREADYOUT;
      @(posedge HCLK);
    end
    chk("accept", ok, 1);
    #1 S_HWDATA = wd;
  endtask

  task automatic drain();
    S_HTRANS = IDLE;
    for (int n = 0; n < 50 && u_act; n++) begin
      @(posedge HCLK);
      #1;
    end
    chk("drain", u_act, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    HRESETn = 1'b0; S_HADDR = '0; S_HTRANS = IDLE; S_HSIZE = BYTE; S_HWRITE = 1'b0; S_HWDATA = '0;
    mem[32'h1004] = 32'hCAFEF00D; mem[32'h3000] = 32'hA; mem[32'h3004] = 32'hB;
    waits[32'h3004] = 2; waits[32'h5000] = 3; errs[32'h6000] = 1'b1;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_ready", S_HREADYOUT, 1);
    chk("rst_resp", S_HRESP, 0);
    chk("rst_rdata", S_HRDATA, 0);
    chk("rst_trans", M_HTRANS, IDLE);
    @(posedge HCLK);
    #1;
    xfer(32'h1004, WORD, 1'b0, 64'd0); drain();
    xfer(32'h2000, DWORD, 1'b1, 64'h11112222_33334444); drain();
    xfer(32'h3000, DWORD, 1'b0, 64'd0); drain();
    xfer(32'h100A, BYTE, 1'b1, 64'h0000_0000_0000_5A00); drain();
    xfer(32'h1002, HALF, 1'b0, 64'd0); drain();
    xfer(32'h1104, WORD, 1'b1, 64'h89ABCDEF_00000000); drain();
    // beat-1 ERROR with a back-to-back NONSEQ held upstream
    xfer(32'h6000, DWORD, 1'b0, 64'd0);
    fork
      begin
        @(negedge HCLK);
        #1;
        chk("err1_trans", M_HTRANS, IDLE);
        chk("err1_ready", S_HREADYOUT, 0);
        chk("err1_resp", S_HRESP, 1);
      end
    join_none
    xfer(32'h1004, WORD, 1'b0, 64'd0); drain();
    xfer(32'h4004, DWORD, 1'b0, 64'd0); drain();
    xfer(32'h7000, 3'd5, 1'b0, 64'd0); drain();
    xfer(32'h1004, WORD, 1'b0, 64'd0);
    xfer(32'h2008, DWORD, 1'b1, 64'hDEADBEEF_01234567); drain();
    // asynchronous reset while beat 1 of a DWORD read is still waiting
    xfer(32'h5000, DWORD, 1'b0, 64'd0);
    S_HTRANS = IDLE;
    @(negedge HCLK);
    #2 chk("pre_rst_stall", S_HREADYOUT, 0);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_ready", S_HREADYOUT, 1);
    chk("mid_rst_resp", S_HRESP, 0);
    chk("mid_rst_trans", M_HTRANS, IDLE);
    dn_q.delete(); up_q.delete(); wq.delete();
    @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("post_rst_trans", M_HTRANS, IDLE);
    @(posedge HCLK);
    #1;
    xfer(32'h1004, WORD, 1'b0, 64'd0); drain();
    repeat (2) @(posedge HCLK);
    chk("dn_left", dn_q.size(), 0);
    chk("up_left", up_q.size(), 0);
    chk("wq_left", wq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
